// File: rtl/core_bus_pkg.sv
// Shared definitions for the 8085-style bus sequencer: T-state codes,
// machine-cycle type codes and the strobe select decode.
package core_bus_pkg;

  localparam int MT_W = 3;
  localparam int TS_W = 4;

  typedef enum logic [TS_W-1:0] {
    ST_TR = 4'b0000,
    ST_T1 = 4'b0001,
    ST_T2 = 4'b0010,
    ST_T3 = 4'b0011,
    ST_T4 = 4'b0100,
    ST_T5 = 4'b0101,
    ST_T6 = 4'b0110,
    ST_TH = 4'b0111,
    ST_TW = 4'b1000,
    ST_TT = 4'b1001,
    ST_TI = 4'b1010
  } tstate_t;

  // Encoded as {iom_n, s1, s0}; 100 is unused.
  typedef enum logic [MT_W-1:0] {
    MT_BI   = 3'b000,
    MT_MW   = 3'b001,
    MT_MR   = 3'b010,
    MT_OF   = 3'b011,
    MT_IOW  = 3'b101,
    MT_IOR  = 3'b110,
    MT_INTA = 3'b111
  } mtype_t;

  typedef struct packed {
    logic rd;
    logic wr;
    logic inta;
  } strobe_sel_t;

  function automatic strobe_sel_t strobe_sel(input logic [MT_W-1:0] mt);
    strobe_sel_t r;
    r = '0;
    case (mt)
      MT_MR, MT_OF, MT_IOR: r.rd   = 1'b1;
      MT_MW, MT_IOW:        r.wr   = 1'b1;
      MT_INTA:              r.inta = 1'b1;
      default:              r      = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/bus_cycle_seq_if.sv
// Request/bus-pin bundle between the microsequencer, the cycle sequencer and the pads.
// Valid/ready: a request is accepted when req is high at a dispatch point; ack marks T1.
interface bus_cycle_seq_if;
  import core_bus_pkg::*;

  logic            req;
  logic [MT_W-1:0] mtype;
  logic            six;
  logic            halt;
  logic            ready;
  logic            hold;
  logic            ack;
  logic            done;
  logic            busy;
  logic [TS_W-1:0] tstate;
  logic            ale;
  logic            rd_n;
  logic            wr_n;
  logic            inta_n;
  logic [1:0]      s;
  logic            iom_n;
  logic            hlda;
  logic            bus_en;

  modport master (
    output req, mtype, six, halt, ready, hold,
    input  ack, done, busy, tstate, ale, rd_n, wr_n, inta_n, s, iom_n, hlda, bus_en
  );

  modport slave (
    input  req, mtype, six, halt, ready, hold,
    output ack, done, busy, tstate, ale, rd_n, wr_n, inta_n, s, iom_n, hlda, bus_en
  );
endinterface

// File: rtl/bus_wait_timer.sv
// Loadable down-counter holding the remaining automatic wait states of a cycle.
module bus_wait_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);
  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/bus_cycle_seq.sv
// Machine-cycle sequencer: steps T1..T3 (T4/T6 for opcode fetch) with READY and
// automatic waits, plus hold and halt. All pin outputs are registered from the next state.
module bus_cycle_seq
  import core_bus_pkg::*;
#(
  parameter int AUTO_WAIT = 0,
  parameter int WCNT_W    = 3
) (
  input logic             clk,
  input logic             rst,
  bus_cycle_seq_if.slave  bus
);
  localparam logic [WCNT_W-1:0] AUTO_WAIT_V = WCNT_W'(AUTO_WAIT);

  tstate_t         state_q, state_d;
  logic [MT_W-1:0] mtype_q;
  logic            six_q;
  logic            wait_zero, wait_load, wait_dec;
  logic [WCNT_W-1:0] wait_load_val;
  logic            done_now, strobe_act_d, busy_d;
  strobe_sel_t     sel_d;

  logic       ack_q, done_q, busy_q, ale_q, rd_n_q, wr_n_q, inta_n_q;
  logic [1:0] s_q;
  logic       iom_n_q, hlda_q, bus_en_q;

  function automatic logic cycle_done(input tstate_t st, input logic [MT_W-1:0] mt,
                                      input logic six);
    return ((st == ST_T3) && (mt != MT_OF)) || ((st == ST_T4) && !six) || (st == ST_T6);
  endfunction

  function automatic tstate_t dispatch(input logic hold, input logic req, input logic halt);
    if (hold)      return ST_TH;
    else if (req)  return ST_T1;
    else if (halt) return ST_TT;
    else           return ST_TI;
  endfunction

  always_comb begin
    state_d  = state_q;
    done_now = cycle_done(state_q, mtype_q, six_q);
    case (state_q)
      ST_TR: state_d = ST_TI;
      ST_TI: state_d = dispatch(bus.hold, bus.req, bus.halt);
      ST_T1: state_d = ST_T2;
      ST_T2: state_d = ((mtype_q != MT_BI) && (!wait_zero || !bus.ready)) ? ST_TW : ST_T3;
      ST_TW: state_d = (wait_zero && (bus.ready || (mtype_q == MT_BI))) ? ST_T3 : ST_TW;
      ST_T3: state_d = done_now ? dispatch(bus.hold, bus.req, bus.halt) : ST_T4;
      ST_T4: state_d = done_now ? dispatch(bus.hold, bus.req, bus.halt) : ST_T5;
      ST_T5: state_d = ST_T6;
      ST_T6: state_d = dispatch(bus.hold, bus.req, bus.halt);
      ST_TH: state_d = bus.hold ? ST_TH : ST_TI;
      ST_TT: state_d = bus.hold ? ST_TH : (bus.halt ? ST_TT : ST_TI);
      default: state_d = ST_TR;
    endcase

    // Counting down already in T2 makes AUTO_WAIT=N give exactly N wait states.
    wait_load     = (state_d == ST_T1);
    wait_load_val = (bus.mtype == MT_BI) ? '0 : AUTO_WAIT_V;
    wait_dec      = ((state_q == ST_T2) || (state_q == ST_TW)) && !wait_zero;

    sel_d        = strobe_sel(mtype_q);
    strobe_act_d = (state_d == ST_T2) || (state_d == ST_TW) || (state_d == ST_T3);
    busy_d       = (state_d inside {ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_TW});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_TR;
      mtype_q  <= '0;
      six_q    <= 1'b0;
      ack_q    <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      inta_n_q <= 1'b1;
      s_q      <= 2'b00;
      iom_n_q  <= 1'b0;
      hlda_q   <= 1'b0;
      bus_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_d == ST_T1) begin
        mtype_q <= bus.mtype;
        six_q   <= bus.six;
      end
      ack_q    <= (state_d == ST_T1);
      ale_q    <= (state_d == ST_T1);
      done_q   <= cycle_done(state_d, mtype_q, six_q);
      busy_q   <= busy_d;
      rd_n_q   <= !(strobe_act_d && sel_d.rd);
      wr_n_q   <= !(strobe_act_d && sel_d.wr);
      inta_n_q <= !(strobe_act_d && sel_d.inta);
      hlda_q   <= (state_d == ST_TH);
      bus_en_q <= busy_d || (state_d == ST_TI);
      // Status follows the new cycle type from T1; TH keeps whatever was last driven.
      if (state_d == ST_T1) begin
        s_q     <= bus.mtype[1:0];
        iom_n_q <= bus.mtype[2];
      end else if (state_d == ST_TT) begin
        s_q <= 2'b00;
      end
    end
  end

  bus_wait_timer #(.W(WCNT_W)) u_wait (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wait_load),
    .load_val_i (wait_load_val),
    .dec_i      (wait_dec),
    .zero_o     (wait_zero)
  );

  assign bus.tstate = state_q;
  assign bus.ack    = ack_q;
  assign bus.done   = done_q;
  assign bus.busy   = busy_q;
  assign bus.ale    = ale_q;
  assign bus.rd_n   = rd_n_q;
  assign bus.wr_n   = wr_n_q;
  assign bus.inta_n = inta_n_q;
  assign bus.s      = s_q;
  assign bus.iom_n  = iom_n_q;
  assign bus.hlda   = hlda_q;
  assign bus.bus_en = bus_en_q;
endmodule

// File: doc/bus_cycle_seq.md
# bus_cycle_seq

Parametrised 8085-style machine-cycle sequencer and the successor to the core bus-state controller. It executes one machine cycle per accepted request, stepping T1..T3, or T1..T4/T6 for opcode fetch. Wait states come from the READY pin plus a programmable automatic wait count, and the block also handles HOLD/HLDA and HALT. It sits between the instruction decoder/microsequencer (requests) and the pin drivers (strobes, status, bus enable).

## Interface
Parameters:
- AUTO_WAIT, 0: wait states inserted in every non-idle cycle, on top of any READY-driven waits.
- WCNT_W, 3: wait counter width. AUTO_WAIT < 2**WCNT_W.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- req  in  1  machine-cycle request. Sampled only at dispatch points.
- mtype  in  3  cycle type {iom_n,s1,s0}: 011 OF, 010 MR, 001 MW, 110 IOR, 101 IOW, 111 INTA, 000 bus idle (BI).
- six  in  1  OF uses 6 T-states. Latched with mtype.
- halt  in  1  enter halt at the next dispatch.
- ready  in  1  memory/IO ready.
- hold  in  1  bus hold request.
- ack  out  1  request accepted. High during T1.
- done  out  1  high during the last T-state of the cycle.
- busy  out  1  high in T1..T6 and TW.
- tstate  out  4  current state code.
- ale  out  1  address latch enable.
- rd_n, wr_n, inta_n  out  1 each  active-low strobes.
- s  out  2  status {s1,s0}.
- iom_n  out  1  IO/memory status.
- hlda  out  1  hold acknowledge.
- bus_en  out  1  1 = drive address/data/rd_n/wr_n/iom_n; 0 = pads tristate.

## Operation
- States: TR, TI, T1, T2, TW, T3, T4, T5, T6, TH, TT.
- All outputs are registered and decoded from the next state, so they are valid during the named state.
- Dispatch rule applies in TI and at the end of every cycle (the `done` state). Priority is hold → TH, then req → T1, then halt → TT, else TI.
- On entering T1 the block latches mtype and six, loads the wait counter with AUTO_WAIT (0 for BI), and drives s and iom_n from the latched mtype.
- TR → TI unconditionally.
- T1 → T2.
- T2 → TW if the type is not BI and (wcnt≠0 or ready=0); otherwise T2 → T3.
- TW: decrement wcnt while it is nonzero. TW → T3 once wcnt=0 and ready=1, both evaluated in the same cycle. For BI, ready is ignored.
- T3: done for all types except OF. For OF, T3 → T4.
- T4: done if six=0; otherwise T4 → T5 → T6, and done is in T6.
- TH: hlda=1, bus_en=0, s and iom_n hold their last values. When hold drops, TH → TI.
- TT: s=00, bus_en=0. hold → TH. halt=0 → TI.
- Strobe select:
  - MR/OF/IOR: rd_n.
  - MW/IOW: wr_n.
  - INTA: inta_n.
  - BI: none.
  - The selected strobe is low in T2, TW and T3, and high otherwise.
- ale=1 only in T1. bus_en=1 in T1..T6, TW and TI.
- Reset values and TR outputs: tstate=TR, ale=0, rd_n=wr_n=inta_n=1, s=00, iom_n=0, hlda=0, bus_en=0, ack=done=busy=0, wcnt=0.

## Timing
- Minimum cycle lengths with AUTO_WAIT=0 and ready=1: MR/MW/IO/INTA/BI take 3 clocks, OF takes 4, 6-state OF takes 6.
- Each wait state adds exactly one clock.
- A req held high at done starts T1 on the next clock, so back-to-back cycles have zero idle clocks.
- hold during a cycle is honoured only at done. TH is entered the clock after done.
- HLDA drops in the same clock the block leaves TH.
- mtype, six and req changes outside dispatch points are ignored.
- Asserting rst mid-cycle forces the TR values immediately, asynchronously.
- Releasing rst gives TR for 1 clock, then TI.

## Structure
- Shared package core_bus_pkg holds:
  - state codes: TR=0000, T1..T6=0001..0110, TH=0111, TW=1000, TT=1001, TI=1010;
  - the mtype codes;
  - the strobe-select function.
- One sub-module, bus_wait_timer: a loadable down-counter (load, dec, zero flag) of width WCNT_W.

## Test plan
- Reset/idle: assert rst, release with no inputs → TR for 1 clock then TI, and every output equals the listed reset value except bus_en=1 in TI.
- OF with six=0, ready=1, AUTO_WAIT=0, and req held → T1,T2,T3,T4 then T1 again; ale high 1 clock; rd_n low 2 clocks; done in T4.
- MW with ready low for 3 clocks starting at T2 → 3 TW states; wr_n low 5 clocks; s=01, iom_n=0.
- AUTO_WAIT=2, MR with ready=1 → exactly 2 TW. A following BI cycle with ready=0 → no TW, no strobes, 3 clocks.
- hold raised in T2 of IOR → cycle completes, then TH with hlda=1 and bus_en=0. Drop hold → TI, then a pending req → T1.
- halt with no req → TT with s=00. hold → TH; release → TI. Assert rst in T2 of an OF → outputs return to reset values within the same clock.
